// File: rtl/contador_regressivo.sv
// rtl/contador_regressivo.sv - loadable down-counting timer with terminal pulse and auto-reload
module contador_regressivo #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             zera,
  input  logic             carrega,
  input  logic             conta,
  input  logic             recarga,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             ocupado,
  output logic             fim,
  output logic             rbo
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONTANDO = 2'd1,
    FIM      = 2'd2
  } estado_t;

  estado_t          estado, estado_prox;
  logic [WIDTH-1:0] valor, valor_prox;
  logic [WIDTH-1:0] q_prox;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
      Q      <= '0;
      valor  <= '0;
    end else begin
      estado <= estado_prox;
      Q      <= q_prox;
      valor  <= valor_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    q_prox      = Q;
    valor_prox  = valor;
    if (zera) begin
      q_prox      = '0;
      estado_prox = OCIOSO;
    end else if (carrega) begin
      q_prox      = D;
      valor_prox  = D;
      estado_prox = (D != '0) ? CONTANDO : FIM;
    end else begin
      case (estado)
        OCIOSO: begin
          estado_prox = OCIOSO;
        end
        CONTANDO: begin
          // Q is never 0 here: a zero load goes straight to FIM
          if (conta) begin
            if (Q == WIDTH'(1)) begin
              q_prox      = '0;
              estado_prox = FIM;
            end else begin
              q_prox = Q - WIDTH'(1);
            end
          end
        end
        FIM: begin
          if (recarga) begin
            if (valor != '0) begin
              q_prox      = valor;
              estado_prox = CONTANDO;
            end else begin
              estado_prox = FIM;
            end
          end else begin
            estado_prox = OCIOSO;
          end
        end
        default: begin
          q_prox      = '0;
          estado_prox = OCIOSO;
        end
      endcase
    end
  end

  assign ocupado = (estado == CONTANDO);
  assign fim     = (estado == FIM);
  assign rbo     = conta && (Q == '0);

endmodule

// File: tb/tb_contador_regressivo.sv
// tb/tb_contador_regressivo.sv - directed self-checking bench for contador_regressivo
module tb_contador_regressivo;

  logic       clock;
  logic       reset;
  logic       zera;
  logic       carrega;
  logic       conta;
  logic       recarga;
  logic [3:0] D;
  logic [3:0] Q;
  logic       ocupado;
  logic       fim;
  logic       rbo;

  int checks = 0;
  int errors = 0;

  contador_regressivo #(.WIDTH(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .zera    (zera),
    .carrega (carrega),
    .conta   (conta),
    .recarga (recarga),
    .D       (D),
    .Q       (Q),
    .ocupado (ocupado),
    .fim     (fim),
    .rbo     (rbo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] eq, input logic eo,
                           input logic ef);
    check({tag, "_q"}, 32'(Q), 32'(eq));
    check({tag, "_ocupado"}, 32'(ocupado), 32'(eo));
    check({tag, "_fim"}, 32'(fim), 32'(ef));
  endtask

  initial begin
    reset = 1'b1; zera = 1'b0; carrega = 1'b0; conta = 1'b0; recarga = 1'b0; D = 4'd0;
    step();
    check_all("reset", 4'd0, 1'b0, 1'b0);
    reset = 1'b0;

    // Reset mid-count
    carrega = 1'b1; D = 4'd5; conta = 1'b1;
    step();
    check_all("rst_load", 4'd5, 1'b1, 1'b0);
    carrega = 1'b0;
    step();
    step();
    check("rst_cnt2_q", 32'(Q), 32'd3);
    #2 reset = 1'b1;
    #1;
    check_all("rst_async", 4'd0, 1'b0, 1'b0);
    check("rst_async_rbo", 32'(rbo), 32'd1);
    #1 reset = 1'b0;
    step();
    check_all("rst_after", 4'd0, 1'b0, 1'b0);

    // Basic count 3,2,1,0
    carrega = 1'b1; D = 4'd3; conta = 1'b1; recarga = 1'b0;
    step();
    check_all("basic_load", 4'd3, 1'b1, 1'b0);
    carrega = 1'b0;
    step();
    check_all("basic_2", 4'd2, 1'b1, 1'b0);
    check("basic_rbo_nz", 32'(rbo), 32'd0);
    step();
    check_all("basic_1", 4'd1, 1'b1, 1'b0);
    step();
    check_all("basic_fim", 4'd0, 1'b0, 1'b1);
    step();
    check_all("basic_idle", 4'd0, 1'b0, 1'b0);

    // Pause: 4,3,2,2,2,2,1,0
    carrega = 1'b1; D = 4'd4; conta = 1'b1;
    step();
    check_all("pause_load", 4'd4, 1'b1, 1'b0);
    carrega = 1'b0;
    step();
    check_all("pause_3", 4'd3, 1'b1, 1'b0);
    step();
    check_all("pause_2", 4'd2, 1'b1, 1'b0);
    conta = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("pause_hold", 4'd2, 1'b1, 1'b0);
    end
    check("pause_rbo", 32'(rbo), 32'd0);
    conta = 1'b1;
    step();
    check_all("pause_1", 4'd1, 1'b1, 1'b0);
    step();
    check_all("pause_fim", 4'd0, 1'b0, 1'b1);
    step();
    check_all("pause_idle", 4'd0, 1'b0, 1'b0);

    // Auto-reload: 2,1,0,2,1,0
    recarga = 1'b1; carrega = 1'b1; D = 4'd2; conta = 1'b1;
    step();
    check_all("ar_load", 4'd2, 1'b1, 1'b0);
    carrega = 1'b0;
    step();
    check_all("ar_1a", 4'd1, 1'b1, 1'b0);
    step();
    check_all("ar_fim_a", 4'd0, 1'b0, 1'b1);
    step();
    check_all("ar_reload", 4'd2, 1'b1, 1'b0);
    step();
    check_all("ar_1b", 4'd1, 1'b1, 1'b0);
    step();
    check_all("ar_fim_b", 4'd0, 1'b0, 1'b1);
    recarga = 1'b0;
    step();
    check_all("ar_stop", 4'd0, 1'b0, 1'b0);

    // zera beats carrega in CONTANDO
    carrega = 1'b1; D = 4'd5;
    step();
    carrega = 1'b0;
    step();
    check_all("prio_cnt", 4'd4, 1'b1, 1'b0);
    zera = 1'b1; carrega = 1'b1; D = 4'd9;
    step();
    check_all("prio_zera", 4'd0, 1'b0, 1'b0);
    zera = 1'b0; carrega = 1'b0;

    // Restart mid-count with 7
    carrega = 1'b1; D = 4'd4;
    step();
    carrega = 1'b0;
    step();
    step();
    check("restart_pre", 32'(Q), 32'd2);
    carrega = 1'b1; D = 4'd7;
    step();
    check_all("restart", 4'd7, 1'b1, 1'b0);
    carrega = 1'b0;
    step();
    check_all("restart_6", 4'd6, 1'b1, 1'b0);
    zera = 1'b1;
    step();
    check_all("zera", 4'd0, 1'b0, 1'b0);
    zera = 1'b0;

    // Load 0 -> FIM next cycle, then idle
    carrega = 1'b1; D = 4'd0; conta = 1'b0;
    step();
    check_all("load0", 4'd0, 1'b0, 1'b1);
    carrega = 1'b0;
    step();
    check_all("load0_idle", 4'd0, 1'b0, 1'b0);

    // Load 0 with recarga: fim held high
    recarga = 1'b1; carrega = 1'b1;
    step();
    carrega = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_all("load0_hold", 4'd0, 1'b0, 1'b1);
      step();
    end
    check_all("load0_hold_end", 4'd0, 1'b0, 1'b1);
    recarga = 1'b0;
    step();
    check_all("load0_rel", 4'd0, 1'b0, 1'b0);

    // Load 15: fim after 15 edges
    carrega = 1'b1; D = 4'd15; conta = 1'b1;
    step();
    check_all("max_load", 4'd15, 1'b1, 1'b0);
    carrega = 1'b0;
    for (int i = 1; i < 15; i++) begin
      step();
      check_all("max_cnt", 4'(15 - i), 1'b1, 1'b0);
    end
    step();
    check_all("max_fim", 4'd0, 1'b0, 1'b1);
    step();
    check_all("max_idle", 4'd0, 1'b0, 1'b0);

    // rbo combinational on conta with Q == 0
    conta = 1'b0;
    #1;
    check("rbo_off", 32'(rbo), 32'd0);
    conta = 1'b1;
    #1;
    check("rbo_on", 32'(rbo), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_regressivo.md
# contador_regressivo

Loadable down-counting timer: the count-down counterpart of the datapath's 4-bit up counter. It loads a start value, decrements it under an enable, raises a one-cycle `fim` pulse on reaching zero, and optionally reloads itself for periodic operation. It feeds the control unit's timeout and interval logic, and `rbo` allows cascading to wider down counters.

## Interface
- `WIDTH`, default 4: count width in bits.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `zera`  in  1  synchronous clear, active-high.
- `carrega`  in  1  synchronous load/start, active-high.
- `conta`  in  1  count enable, active-high.
- `recarga`  in  1  auto-reload mode select.
- `D`  in  WIDTH  start value sampled on load.
- `Q`  out  WIDTH  current count.
- `ocupado`  out  1  high while in CONTANDO.
- `fim`  out  1  terminal pulse, high only in state FIM.
- `rbo`  out  1  ripple borrow out: `conta && (Q == 0)`, combinational.

## Operation
- Internal registers: `Q`, `valor` (last loaded value, WIDTH bits), and state in {OCIOSO, CONTANDO, FIM}.
- `reset` high, at any time and mid-count: state OCIOSO, `Q`=0, `valor`=0, so `ocupado`=0 and `fim`=0. `rbo` still follows `conta`.
- Input priority, in every state: `zera` > `carrega` > `conta`.
- `zera`: `Q`<=0, state<=OCIOSO. `valor` is kept.
- `carrega`, from any state: `Q`<=`D`, `valor`<=`D`.
  - If `D`!=0, state<=CONTANDO.
  - If `D`==0, state<=FIM.
  - A load during CONTANDO restarts the count.
- OCIOSO: `Q` holds. `conta` is ignored.
- CONTANDO, with `conta`=1:
  - If `Q`==1: `Q`<=0 and state<=FIM.
  - Otherwise: `Q`<=`Q`-1.
- CONTANDO, with `conta`=0: `Q` holds (pause). State holds.
- FIM lasts exactly one cycle unless `zera` or `carrega` is asserted.
  - If `recarga`=1 and `valor`!=0: `Q`<=`valor`, state<=CONTANDO.
  - If `recarga`=1 and `valor`==0: state<=FIM again, so `fim` stays high continuously.
  - If `recarga`=0: state<=OCIOSO and `Q` stays 0.
- `Q` never wraps. The decrement below 0 is unreachable by construction. The value 2^WIDTH-1 is a legal load.
- Moore outputs: `ocupado` = (state==CONTANDO); `fim` = (state==FIM).

## Timing
- Load latency: `Q`=`D` is visible the cycle after the `carrega` edge.
- Count latency with `conta` held at 1: `fim` rises exactly `D` rising edges after the load edge and stays high for one cycle.
- Each cycle with `conta`=0 adds one cycle of delay.
- Auto-reload period with `conta` held at 1: `fim` pulses every `D`+1 cycles (D decrement cycles plus the FIM cycle).
- `rbo` has zero-cycle latency. It is asserted in OCIOSO and FIM whenever `conta`=1, because `Q`==0 there.
- `reset` takes effect immediately, with no clock needed. Release is synchronous to the next rising edge.

## Test plan
- Reset mid-count: load 5, count 2 cycles, pulse `reset` between edges -> `Q`=0, `ocupado`=0, `fim`=0 immediately. The next edge with `conta`=1 leaves `Q`=0.
- Basic count: load 3, `conta`=1, `recarga`=0 -> `Q` sequence 3,2,1,0. `fim`=1 exactly on the 3rd edge after load, for one cycle. Then OCIOSO with `Q`=0.
- Pause: load 4, `conta`=1 for 2 cycles, 0 for 3, then 1 -> `Q` 4,3,2,2,2,2,1,0. `fim` is delayed by 3 cycles.
- Auto-reload: `recarga`=1, load 2, `conta`=1 -> `fim` pulses every 3 cycles, with `Q` 2,1,0,2,1,0…
- Priority and restart:
  - `zera`+`carrega` together in CONTANDO -> `Q`=0, OCIOSO.
  - `carrega` with D=7 while `Q`=2 -> `Q`=7, no `fim` pulse.
- Edges of the range:
  - Load 0 -> `fim` high the next cycle.
  - Load 15 (WIDTH=4) -> `fim` after 15 edges.
  - `rbo`=1 only when `conta`=1 and `Q`=0.
